// File: rtl/zapper_round_ctrl_if.sv
// Signal bundle between the zapper front end, the controller and the renderer/duck logic.
// The controller takes the slave side; the environment driving the zapper takes the master side.
interface zapper_round_ctrl_if;
   logic       frame_tick;
   logic       trigger;
   logic       detect;
   logic       duck_landed;
   logic       flash_black;
   logic       flash_white;
   logic       duck_hit;
   logic       new_duck;
   logic       fly_away;
   logic [1:0] shots_left;
   logic [3:0] hit_count;
   logic [3:0] round_num;
   logic [3:0] speed;
   logic [1:0] game_state;

   modport master (
      output frame_tick, trigger, detect, duck_landed,
      input  flash_black, flash_white, duck_hit, new_duck, fly_away,
      input  shots_left, hit_count, round_num, speed, game_state
   );

   modport slave (
      input  frame_tick, trigger, detect, duck_landed,
      output flash_black, flash_white, duck_hit, new_duck, fly_away,
      output shots_left, hit_count, round_num, speed, game_state
   );
endinterface

// File: rtl/zapper_round_ctrl.sv
// Frame-rate shot/round sequencer for the zapper game: flash ordering, hit sampling, scoring.
// Optional macro FLYAWAY_TIMEOUT_EN adds the ARMED fly-away timeout; otherwise fly_away is tied low.
module zapper_round_ctrl #(
   parameter int SHOTS_PER_ROUND = 3,
   parameter int ROUNDS_PER_GAME = 10,
   parameter int ROUND_PAUSE     = 60,
   parameter int BASE_SPEED      = 3,
   parameter int MAX_SPEED       = 15,
   parameter int FLYAWAY_FRAMES  = 300
) (
   input  logic               clk,
   input  logic               rst,
   zapper_round_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_START,
      ST_ARMED,
      ST_FLASH_BLACK,
      ST_FLASH_WHITE,
      ST_DUCK_FALL,
      ST_ROUND_END,
      ST_GAME_OVER
   } state_t;

   localparam logic [1:0] GS_START = 2'b00;
   localparam logic [1:0] GS_PLAY  = 2'b01;
   localparam logic [1:0] GS_OVER  = 2'b10;

   localparam logic [1:0] SHOTS_INIT = 2'(SHOTS_PER_ROUND);
   localparam logic [3:0] ROUND_LAST = 4'(ROUNDS_PER_GAME);
   localparam logic [3:0] SPEED_BASE = 4'(BASE_SPEED);
   localparam logic [3:0] SPEED_MAX  = 4'(MAX_SPEED);

   // Pause and fly-away counters share one width, sized for the longer of the two.
   localparam int CNT_MAX = (ROUND_PAUSE > FLYAWAY_FRAMES) ? ROUND_PAUSE : FLYAWAY_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(ROUND_PAUSE - 1);

   state_t           r_state;
   logic [1:0]       r_game_state;
   logic             r_flash_black;
   logic             r_flash_white;
   logic             r_duck_hit;
   logic             r_new_duck;
   logic [1:0]       r_shots;
   logic [3:0]       r_hits;
   logic [3:0]       r_round;
   logic [3:0]       r_speed;
   logic             r_trig_q;
   logic             r_hit_latch;
   logic             r_round_hit;
   logic [CNT_W-1:0] r_pause;
   logic             w_press;

   assign w_press = bus.frame_tick & bus.trigger & ~r_trig_q;

`ifdef FLYAWAY_TIMEOUT_EN
   localparam logic [CNT_W-1:0] FLY_LAST = CNT_W'(FLYAWAY_FRAMES - 1);
   logic [CNT_W-1:0] r_fly_cnt;
   logic             r_fly_away;
   logic             w_fly_expire;

   // Expiry happens on the tick that would be the FLYAWAY_FRAMES-th one spent armed.
   assign w_fly_expire = bus.frame_tick & ~w_press & (r_fly_cnt >= FLY_LAST);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_START;
         r_game_state  <= GS_START;
         r_flash_black <= 1'b0;
         r_flash_white <= 1'b0;
         r_duck_hit    <= 1'b0;
         r_new_duck    <= 1'b0;
         r_shots       <= 2'd0;
         r_hits        <= 4'd0;
         r_round       <= 4'd0;
         r_speed       <= SPEED_BASE;
         r_trig_q      <= 1'b0;
         r_hit_latch   <= 1'b0;
         r_round_hit   <= 1'b0;
         r_pause       <= '0;
`ifdef FLYAWAY_TIMEOUT_EN
         r_fly_cnt     <= '0;
         r_fly_away    <= 1'b0;
`endif
      end else begin
         r_duck_hit <= 1'b0;
         r_new_duck <= 1'b0;
`ifdef FLYAWAY_TIMEOUT_EN
         r_fly_away <= 1'b0;
`endif
         if (bus.frame_tick) begin
            r_trig_q <= bus.trigger;
         end

         case (r_state)
            ST_START: begin
               if (w_press) begin
                  r_round      <= 4'd1;
                  r_hits       <= 4'd0;
                  r_shots      <= SHOTS_INIT;
                  r_speed      <= SPEED_BASE;
                  r_new_duck   <= 1'b1;
                  r_game_state <= GS_PLAY;
                  r_state      <= ST_ARMED;
`ifdef FLYAWAY_TIMEOUT_EN
                  r_fly_cnt    <= '0;
`endif
               end
            end

            ST_ARMED: begin
               if (w_press) begin
                  if (r_shots != 2'd0) begin
                     r_shots <= r_shots - 2'd1;
                  end
                  r_flash_black <= 1'b1;
                  r_state       <= ST_FLASH_BLACK;
               end
`ifdef FLYAWAY_TIMEOUT_EN
               else if (w_fly_expire) begin
                  r_fly_away  <= 1'b1;
                  r_round_hit <= 1'b0;
                  r_pause     <= '0;
                  r_state     <= ST_ROUND_END;
               end
               if (bus.frame_tick && (r_fly_cnt < FLY_LAST)) begin
                  r_fly_cnt <= r_fly_cnt + CNT_ONE;
               end
`endif
            end

            ST_FLASH_BLACK: begin
               if (bus.frame_tick) begin
                  r_flash_black <= 1'b0;
                  r_flash_white <= 1'b1;
                  r_hit_latch   <= 1'b0;
                  r_state       <= ST_FLASH_WHITE;
               end
            end

            ST_FLASH_WHITE: begin
               r_hit_latch <= r_hit_latch | bus.detect;
               if (bus.frame_tick) begin
                  r_flash_white <= 1'b0;
                  // detect is also taken on the verdict tick itself, not only via the latch.
                  if (r_hit_latch || bus.detect) begin
                     r_duck_hit  <= 1'b1;
                     r_hits      <= r_hits + 4'd1;
                     r_round_hit <= 1'b1;
                     r_state     <= ST_DUCK_FALL;
                  end else if (r_shots == 2'd0) begin
                     r_round_hit <= 1'b0;
                     r_pause     <= '0;
                     r_state     <= ST_ROUND_END;
                  end else begin
                     r_state <= ST_ARMED;
                  end
               end
            end

            ST_DUCK_FALL: begin
               if (bus.duck_landed) begin
                  r_pause <= '0;
                  r_state <= ST_ROUND_END;
               end
            end

            ST_ROUND_END: begin
               if (bus.frame_tick) begin
                  if (r_pause == PAUSE_LAST) begin
                     if (r_round == ROUND_LAST) begin
                        r_game_state <= GS_OVER;
                        r_state      <= ST_GAME_OVER;
                     end else begin
                        r_round    <= r_round + 4'd1;
                        r_shots    <= SHOTS_INIT;
                        r_new_duck <= 1'b1;
                        r_state    <= ST_ARMED;
`ifdef FLYAWAY_TIMEOUT_EN
                        r_fly_cnt  <= '0;
`endif
                        if (r_round_hit) begin
                           r_speed <= (r_speed >= SPEED_MAX) ? SPEED_MAX : r_speed + 4'd1;
                        end
                     end
                  end else begin
                     r_pause <= r_pause + CNT_ONE;
                  end
               end
            end

            ST_GAME_OVER: begin
               if (w_press) begin
                  r_game_state <= GS_START;
                  r_state      <= ST_START;
               end
            end

            default: begin
               r_game_state <= GS_START;
               r_state      <= ST_START;
            end
         endcase
      end
   end

   assign bus.flash_black = r_flash_black;
   assign bus.flash_white = r_flash_white;
   assign bus.duck_hit    = r_duck_hit;
   assign bus.new_duck    = r_new_duck;
   assign bus.shots_left  = r_shots;
   assign bus.hit_count   = r_hits;
   assign bus.round_num   = r_round;
   assign bus.speed       = r_speed;
   assign bus.game_state  = r_game_state;
`ifdef FLYAWAY_TIMEOUT_EN
   assign bus.fly_away    = r_fly_away;
`else
   assign bus.fly_away    = 1'b0;
`endif

endmodule

// File: tb/tb_zapper_round_ctrl.sv
// Self-checking bench for zapper_round_ctrl: directed game scenarios plus randomized frames,
// compared every cycle against a game-level reference model.
module tb_zapper_round_ctrl;

   localparam int SHOTS  = 3;
   localparam int ROUNDS = 10;
   localparam int PAUSE  = 60;
   localparam int BASE   = 3;
   localparam int MAXS   = 15;
   localparam int FLY    = 300;

   localparam int P_IDLE  = 0;
   localparam int P_WAIT  = 1;
   localparam int P_DARK  = 2;
   localparam int P_LIGHT = 3;
   localparam int P_FALL  = 4;
   localparam int P_PAUSE = 5;
   localparam int P_OVER  = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;

   zapper_round_ctrl_if bus();

   zapper_round_ctrl #(
      .SHOTS_PER_ROUND(SHOTS),
      .ROUNDS_PER_GAME(ROUNDS),
      .ROUND_PAUSE    (PAUSE),
      .BASE_SPEED     (BASE),
      .MAX_SPEED      (MAXS),
      .FLYAWAY_FRAMES (FLY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_fly    = 0;
   bit chk_en   = 1'b0;

   // Game-level model: shots fired, completed hit rounds and frames waited, not shots-left or speed registers.
   int m_ph;
   int m_fired;
   int m_hits;
   int m_round;
   int m_hit_rounds;
   int m_waited;
   int m_armed_ticks;
   bit m_started;
   bit m_trig_prev;
   bit m_seen;
   bit m_last_hit;
   bit e_hit;
   bit e_new;
   bit e_fly;

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic int exp_shots();
      return m_started ? (SHOTS - m_fired) : 0;
   endfunction

   function automatic int exp_speed();
      int s;
      s = BASE + m_hit_rounds;
      return (s > MAXS) ? MAXS : s;
   endfunction

   function automatic int exp_gs();
      if (m_ph == P_IDLE) return 0;
      if (m_ph == P_OVER) return 2;
      return 1;
   endfunction

   task automatic model_reset();
      m_ph          = P_IDLE;
      m_fired       = 0;
      m_hits        = 0;
      m_round       = 0;
      m_hit_rounds  = 0;
      m_waited      = 0;
      m_armed_ticks = 0;
      m_started     = 1'b0;
      m_trig_prev   = 1'b0;
      m_seen        = 1'b0;
      m_last_hit    = 1'b0;
   endtask

   task automatic model_step(input bit r, input bit t, input bit tr, input bit d, input bit l);
      bit press;
      e_hit = 1'b0;
      e_new = 1'b0;
      e_fly = 1'b0;
      if (r) begin
         model_reset();
         return;
      end
      press = t && tr && !m_trig_prev;
      if (t) m_trig_prev = tr;
      case (m_ph)
         P_IDLE: if (press) begin
            m_started = 1'b1; m_round = 1; m_hits = 0; m_fired = 0;
            m_hit_rounds = 0; m_armed_ticks = 0; e_new = 1'b1; m_ph = P_WAIT;
         end
         P_WAIT: begin
            if (press) begin
               m_fired++;
               m_ph = P_DARK;
            end
`ifdef FLYAWAY_TIMEOUT_EN
            if (t) m_armed_ticks++;
            if (t && !press && m_armed_ticks >= FLY) begin
               e_fly = 1'b1; m_last_hit = 1'b0; m_waited = 0; m_ph = P_PAUSE;
            end
`endif
         end
         P_DARK: if (t) begin
            m_seen = 1'b0;
            m_ph   = P_LIGHT;
         end
         P_LIGHT: begin
            m_seen = m_seen | d;
            if (t) begin
               if (m_seen) begin
                  e_hit = 1'b1; m_hits++; m_last_hit = 1'b1; m_ph = P_FALL;
               end else if (m_fired == SHOTS) begin
                  m_last_hit = 1'b0; m_waited = 0; m_ph = P_PAUSE;
               end else begin
                  m_ph = P_WAIT;
               end
            end
         end
         P_FALL: if (l) begin
            m_waited = 0;
            m_ph     = P_PAUSE;
         end
         P_PAUSE: if (t) begin
            m_waited++;
            if (m_waited == PAUSE) begin
               if (m_round == ROUNDS) begin
                  m_ph = P_OVER;
               end else begin
                  m_round++; m_fired = 0; m_armed_ticks = 0; e_new = 1'b1; m_ph = P_WAIT;
                  if (m_last_hit) m_hit_rounds++;
               end
            end
         end
         P_OVER: if (press) m_ph = P_IDLE;
         default: m_ph = P_IDLE;
      endcase
   endtask

   // Compare process: every cycle, just after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (chk_en) begin
            check("flash_black", bus.flash_black, (m_ph == P_DARK) ? 1 : 0);
            check("flash_white", bus.flash_white, (m_ph == P_LIGHT) ? 1 : 0);
            check("duck_hit",    bus.duck_hit,    e_hit);
            check("new_duck",    bus.new_duck,    e_new);
            check("fly_away",    bus.fly_away,    e_fly);
            check("shots_left",  bus.shots_left,  exp_shots());
            check("hit_count",   bus.hit_count,   m_hits);
            check("round_num",   bus.round_num,   m_round);
            check("speed",       bus.speed,       exp_speed());
            check("game_state",  bus.game_state,  exp_gs());
            if (bus.fly_away) n_fly++;
         end
      end
   end

   task automatic cycle(input bit r, input bit t, input bit tr, input bit d, input bit l);
      @(negedge clk);
      rst             = r;
      bus.frame_tick  = t;
      bus.trigger     = tr;
      bus.detect      = d;
      bus.duck_landed = l;
      model_step(r, t, tr, d, l);
   endtask

   task automatic tick_frame(input int len, input bit trig, input int det_n, input bit landed);
      for (int c = 0; c < len; c++) begin
         cycle(1'b0, c == 0, trig, (c >= 1) && (c <= det_n), landed && (c == 1));
      end
   endtask

   task automatic press_frames();
      tick_frame(4, 1'b0, 0, 1'b0);
      tick_frame(4, 1'b1, 0, 1'b0);
   endtask

   task automatic pause_frames();
      repeat (PAUSE) tick_frame(4, 1'b0, 0, 1'b0);
   endtask

   task automatic hit_round();
      press_frames();
      tick_frame(8, 1'b0, 5, 1'b0);
      tick_frame(4, 1'b0, 0, 1'b1);
      pause_frames();
   endtask

   initial begin
      int len;
      int dn;
      bit tr;
      bit ld;
      bit rr;

      bus.frame_tick  = 1'b0;
      bus.trigger     = 1'b0;
      bus.detect      = 1'b0;
      bus.duck_landed = 1'b0;
      model_reset();

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset_game_state", bus.game_state, 0);
      check("reset_round", bus.round_num, 0);
      check("reset_shots", bus.shots_left, 0);
      check("reset_hits", bus.hit_count, 0);
      check("reset_speed", bus.speed, 3);
      check("reset_flash_black", bus.flash_black, 0);
      $display("step reset done");

      press_frames();
      check("start_game_state", bus.game_state, 1);
      check("start_round", bus.round_num, 1);
      check("start_shots", bus.shots_left, 3);
      check("start_speed", bus.speed, 3);
      $display("step game start done");

      press_frames();
      check("hit_black_on", bus.flash_black, 1);
      check("hit_shots_after_press", bus.shots_left, 2);
      tick_frame(8, 1'b0, 5, 1'b0);
      check("hit_white_on", bus.flash_white, 1);
      check("hit_black_off", bus.flash_black, 0);
      tick_frame(4, 1'b0, 0, 1'b1);
      check("hit_count_1", bus.hit_count, 1);
      check("hit_white_off", bus.flash_white, 0);
      check("hit_shots_held", bus.shots_left, 2);
      pause_frames();
      check("hit_next_round", bus.round_num, 2);
      check("hit_speed_up", bus.speed, 4);
      check("hit_shots_reload", bus.shots_left, 3);
      $display("step hit round done");

      for (int i = 0; i < 3; i++) begin
         press_frames();
         check("miss_shots_left", bus.shots_left, 2 - i);
         tick_frame(4, 1'b0, 0, 1'b0);
         tick_frame(4, 1'b0, 0, 1'b0);
      end
      check("miss_round_end_state", bus.game_state, 1);
      check("miss_speed_held", bus.speed, 4);
      pause_frames();
      check("miss_next_round", bus.round_num, 3);
      check("miss_speed_after", bus.speed, 4);
      $display("step miss round done");

      repeat (10) tick_frame(4, 1'b1, 0, 1'b0);
      check("held_trig_shots", bus.shots_left, 2);
      check("held_trig_black", bus.flash_black, 0);
      check("held_trig_white", bus.flash_white, 0);
      press_frames();
      tick_frame(4, 1'b0, 0, 1'b0);
      tick_frame(4, 1'b1, 0, 1'b0);
      check("white_press_ignored_shots", bus.shots_left, 1);
      check("white_press_ignored_black", bus.flash_black, 0);
      tick_frame(8, 1'b0, 6, 1'b0);
      tick_frame(8, 1'b0, 6, 1'b0);
      press_frames();
      tick_frame(4, 1'b0, 0, 1'b0);
      tick_frame(4, 1'b0, 0, 1'b0);
      check("armed_detect_ignored", bus.hit_count, 1);
      pause_frames();
      check("ignore_next_round", bus.round_num, 4);
      check("ignore_speed", bus.speed, 4);
      $display("step ignored inputs done");

      for (int f = 0; f < 400; f++) begin
         len = $urandom_range(3, 6);
         tr  = ($urandom_range(0, 1) == 1);
         dn  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : 0;
         ld  = ($urandom_range(0, 3) == 0);
         rr  = ($urandom_range(0, 99) == 0);
         for (int c = 0; c < len; c++) begin
            cycle(rr && (c == 0), c == 0, tr, (c >= 1) && (c <= dn), ld && (c == 1));
         end
      end
      $display("step random frames done");

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      press_frames();
      repeat (ROUNDS) hit_round();
      check("over_game_state", bus.game_state, 2);
      check("over_hit_count", bus.hit_count, 10);
      check("over_speed", bus.speed, 12);
      check("over_round", bus.round_num, 10);
      press_frames();
      check("restart_game_state", bus.game_state, 0);
      check("restart_hits_held", bus.hit_count, 10);
      $display("step full game done");

      press_frames();
      press_frames();
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("midwhite_flash_on", bus.flash_white, 1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("midwhite_rst_flash", bus.flash_white, 0);
      check("midwhite_rst_state", bus.game_state, 0);
      check("midwhite_rst_round", bus.round_num, 0);
      check("midwhite_rst_shots", bus.shots_left, 0);
      check("midwhite_rst_speed", bus.speed, 3);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("step reset mid-flash done");

`ifdef FLYAWAY_TIMEOUT_EN
      press_frames();
      repeat (FLY) tick_frame(4, 1'b0, 0, 1'b0);
      check("flyaway_pulses", n_fly, 1);
      check("flyaway_shots", bus.shots_left, 3);
      check("flyaway_state", bus.game_state, 1);
      $display("step fly-away done");
`else
      check("flyaway_never", n_fly, 0);
`endif

      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/zapper_round_ctrl.md
# zapper_round_ctrl

Frame-rate controller that sequences each zapper shot and each round of a game. It detects trigger presses and orders the black and white flash frames for the renderer. It samples the light sensor during the white frame and tracks shots, hits, rounds and duck speed. It sits between the zapper inputs and the pattern generator and duck motion logic, which consume its flash, speed and event outputs.

## Interface
Parameters:
- SHOTS_PER_ROUND, 3, shots per duck; 1..3.
- ROUNDS_PER_GAME, 10, ducks per game; 1..15.
- ROUND_PAUSE, 60, frames held in ROUND_END.
- BASE_SPEED, 3, speed at game start.
- MAX_SPEED, 15, speed saturation value; ≤15.
- FLYAWAY_FRAMES, 300, frames in ARMED before fly-away; used only with the macro.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, at start of vertical blank.
- trigger  in  1  zapper trigger level, already synchronized.
- detect  in  1  zapper photodiode level, already synchronized.
- duck_landed  in  1  pulse from duck motion when the fall completes.
- flash_black  out  1  high for the whole black flash frame.
- flash_white  out  1  high for the whole white (hit-box) flash frame.
- duck_hit  out  1  one-cycle pulse on a registered hit.
- new_duck  out  1  one-cycle pulse when a duck launches.
- fly_away  out  1  one-cycle pulse on timeout (macro only).
- shots_left  out  2  remaining shots this round.
- hit_count  out  4  hits this game.
- round_num  out  4  current round, 1-based; 0 before first game.
- speed  out  4  duck speed for motion logic.
- game_state  out  2  00 START, 01 PLAY, 10 OVER.

## Operation
- **Trigger edge:** trig_q samples trigger on every frame_tick. A press = frame_tick && trigger && !trig_q. Presses outside START, ARMED or GAME_OVER are discarded, never queued.
- **START → ARMED** on a press:
  - round_num=1, hit_count=0, shots_left=SHOTS_PER_ROUND, speed=BASE_SPEED.
  - Pulse new_duck.
- **ARMED → FLASH_BLACK** on a press; shots_left decrements on that same tick.
- **FLASH_BLACK → FLASH_WHITE** on the next frame_tick; the hit latch clears.
- **FLASH_WHITE:**
  - Every cycle: hit latch |= detect.
  - On the next frame_tick, if latch or detect is set: pulse duck_hit, increment hit_count, go to DUCK_FALL.
  - Otherwise, if shots_left==0: go to ROUND_END (miss).
  - Otherwise: go to ARMED.
- **DUCK_FALL → ROUND_END** on duck_landed. duck_landed in any other state is ignored.
- **ROUND_END:** count ROUND_PAUSE frame_ticks, then:
  - If round_num==ROUNDS_PER_GAME: go to GAME_OVER.
  - Otherwise: increment round_num, reload shots_left, pulse new_duck, go to ARMED.
  - If the finished round was a hit, speed = min(speed+1, MAX_SPEED).
- **GAME_OVER → START** on a press. Counters hold until the next game starts.
- **game_state:** START=00; ARMED, FLASH_*, DUCK_FALL and ROUND_END=01; GAME_OVER=10.

## Timing
- **Reset values:**
  - State START; all pulses and flash outputs 0.
  - shots_left=0, hit_count=0, round_num=0, speed=BASE_SPEED, trig_q=0, hit latch=0.
- rst has priority over frame_tick in the same cycle. Reset mid-flash drops flash outputs on the next cycle.
- All outputs are registered. State changes and pulses occur the cycle after the qualifying frame_tick.
- The flash sequence is exactly one black frame then one white frame, i.e. 2 frames from press to verdict.
- detect outside FLASH_WHITE has no effect.
- Counters never wrap:
  - speed saturates at MAX_SPEED.
  - hit_count is bounded by ROUNDS_PER_GAME.
  - shots_left never decrements below 0; ARMED is never entered with 0.

## Configuration
- FLYAWAY_TIMEOUT_EN defined:
  - A frame counter clears on new_duck and counts frame_ticks only while in ARMED.
  - When the count reaches FLYAWAY_FRAMES, pulse fly_away and go to ROUND_END as a miss, leaving shots_left unchanged.
  - A press and the expiry on the same tick: the press wins.
- FLYAWAY_TIMEOUT_EN undefined: no counter; fly_away tied to 0; a duck stays until hit or out of shots.

## Test plan
- Reset, then a press → next tick: game_state=01, round_num=1, shots_left=3, speed=3, new_duck=1 for one cycle.
- Press in ARMED, detect high for 5 cycles during the white frame → flash_black for 1 frame, then flash_white for 1 frame, then duck_hit pulse, hit_count=1, shots_left=2; duck_landed, then 60 frames → round_num=2, speed=4, shots_left=3.
- Three presses with detect held low → three black/white pairs, shots_left 2,1,0, ROUND_END, no speed change.
- Trigger held high across 10 frames → exactly one flash sequence. A press during FLASH_WHITE and detect high in ARMED → ignored.
- Ten hit rounds → game_state=10, hit_count=10, speed=12; rst asserted mid-FLASH_WHITE → all reset values next cycle.
- With FLYAWAY_TIMEOUT_EN: no press for 300 frames → fly_away pulse, ROUND_END, shots_left=3; without the macro, fly_away stays 0.
